// File: rtl/mlp_layer_sequencer.sv
// Multi-layer control FSM for an ARRAY_N x ARRAY_N systolic MMU: sequences weight load,
// activation load, compute, drain, transfer and ping-pong buffer swap for 1..MAX_LAYERS layers.
module mlp_layer_sequencer #(
    parameter int ARRAY_N         = 2,
    parameter int MAX_LAYERS      = 4,
    parameter int LAYER_W         = 3,
    parameter int ACT_LOAD_CYCLES = 4,
    parameter int TRANSFER_CYCLES = 4,
    parameter int DONE_HOLD       = 8,
    parameter int CNT_W           = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LAYER_W-1:0] num_layers,
    input  logic               weights_ready,
    input  logic               abort,
    input  logic               ub_rd_valid,
    output logic               wf_pop,
    output logic [ARRAY_N-1:0] capture_col,
    output logic               ub_rd_ready,
    output logic               buf_sel,
    output logic               refill_en,
    output logic               acc_clear,
    output logic               acc_align_clear,
    output logic               accum_en,
    output logic               mmu_valid,
    output logic [3:0]         state,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [LAYER_W-1:0] layer,
    output logic               busy,
    output logic               layer_complete,
    output logic               done
);

    typedef enum logic [3:0] {
        S_IDLE         = 4'd0,
        S_LOAD_WEIGHT  = 4'd1,
        S_LOAD_ACT     = 4'd2,
        S_COMPUTE      = 4'd3,
        S_DRAIN        = 4'd4,
        S_TRANSFER     = 4'd5,
        S_NEXT_LAYER   = 4'd6,
        S_WAIT_WEIGHTS = 4'd7,
        S_DONE         = 4'd8
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [LAYER_W-1:0] layer_q, num_q, num_clamped;
    logic               buf_q, accum_q, done_q, acc_clear_q;
    logic               start_ok, abort_run;

    assign start_ok  = (state_q == S_IDLE) && start && !abort;
    assign abort_run = abort && (state_q != S_IDLE);

    always_comb begin
        num_clamped = num_layers;
        if (num_layers == '0)
            num_clamped = LAYER_W'(1);
        else if (num_layers > LAYER_W'(MAX_LAYERS))
            num_clamped = LAYER_W'(MAX_LAYERS);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:         if (start) state_d = S_LOAD_WEIGHT;
            S_LOAD_WEIGHT:  if (cnt_q == CNT_W'(ARRAY_N))
                                state_d = (layer_q == '0) ? S_LOAD_ACT : S_COMPUTE;
            S_LOAD_ACT:     if (cnt_q == CNT_W'(ACT_LOAD_CYCLES - 1)) state_d = S_COMPUTE;
            S_COMPUTE:      if (cnt_q == CNT_W'(ARRAY_N)) state_d = S_DRAIN;
            S_DRAIN:        if (cnt_q == CNT_W'(2 * ARRAY_N + 2))
                                state_d = (layer_q < num_q - 1'b1) ? S_TRANSFER : S_DONE;
            S_TRANSFER:     if (cnt_q == CNT_W'(TRANSFER_CYCLES - 1)) state_d = S_NEXT_LAYER;
            S_NEXT_LAYER:   state_d = S_WAIT_WEIGHTS;
            S_WAIT_WEIGHTS: if (weights_ready) state_d = S_LOAD_WEIGHT;
            S_DONE:         if (cnt_q == CNT_W'(DONE_HOLD)) state_d = S_IDLE;
            default:        state_d = S_IDLE;
        endcase
        // Abort overrides every transition, including start taken in IDLE.
        if (abort) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            layer_q     <= '0;
            num_q       <= '0;
            buf_q       <= 1'b0;
            accum_q     <= 1'b0;
            done_q      <= 1'b0;
            acc_clear_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
            done_q      <= (state_q == S_DONE) && (cnt_q == CNT_W'(DONE_HOLD)) && !abort;
            acc_clear_q <= start_ok;

            if (abort_run || start_ok) begin
                layer_q <= '0;
                buf_q   <= 1'b0;
            end else if (state_q == S_NEXT_LAYER) begin
                layer_q <= layer_q + 1'b1;
                buf_q   <= ~buf_q;
            end
            if (start_ok) num_q <= num_clamped;

            // Accumulation stays enabled across layers until the run leaves for IDLE.
            if (abort || state_d == S_IDLE)
                accum_q <= 1'b0;
            else if (state_q == S_COMPUTE)
                accum_q <= 1'b1;
        end
    end

    // ub_rd_valid/ub_rd_ready: a read beat is consumed on any cycle where both are high;
    // ready is held for the whole COMPUTE window regardless of valid.
    always_comb begin
        capture_col = '0;
        if (state_q == S_LOAD_WEIGHT) begin
            for (int k = 0; k < ARRAY_N; k++)
                capture_col[k] = (cnt_q == CNT_W'(k + 1));
        end
    end

    assign wf_pop          = (state_q == S_LOAD_WEIGHT);
    assign ub_rd_ready     = (state_q == S_COMPUTE);
    assign mmu_valid       = ((state_q == S_COMPUTE) && (cnt_q >= CNT_W'(ARRAY_N)) && ub_rd_valid)
                           || ((state_q == S_DRAIN) && (cnt_q < CNT_W'(ARRAY_N)));
    assign refill_en       = (state_q == S_DRAIN) || (state_q == S_TRANSFER);
    assign acc_clear       = acc_clear_q;
    assign acc_align_clear = (state_q == S_LOAD_ACT) && (cnt_q == '0);
    assign accum_en        = accum_q;
    assign buf_sel         = buf_q;
    assign state           = state_q;
    assign cycle_cnt       = cnt_q;
    assign layer           = layer_q;
    assign busy            = (state_q != S_IDLE);
    assign layer_complete  = (state_q == S_DONE);
    assign done            = done_q;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Bench for mlp_layer_sequencer: each start pushes the expected state segments of the run
// into a queue; a negedge monitor walks the DUT trace against it cycle by cycle.
module tb_mlp_layer_sequencer;
    localparam int N    = 2;
    localparam int MAXL = 4;
    localparam int LW   = 3;
    localparam int ACT  = 4;
    localparam int TC   = 4;
    localparam int DH   = 8;
    localparam int CW   = 5;

    logic          clk = 1'b0;
    logic          reset, start, weights_ready, abort, ub_rd_valid;
    logic [LW-1:0] num_layers;
    logic          wf_pop, ub_rd_ready, buf_sel, refill_en, acc_clear, acc_align_clear;
    logic          accum_en, mmu_valid, busy, layer_complete, done;
    logic [N-1:0]  capture_col;
    logic [3:0]    state;
    logic [CW-1:0] cycle_cnt;
    logic [LW-1:0] layer;

    mlp_layer_sequencer #(
        .ARRAY_N(N), .MAX_LAYERS(MAXL), .LAYER_W(LW), .ACT_LOAD_CYCLES(ACT),
        .TRANSFER_CYCLES(TC), .DONE_HOLD(DH), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_layers(num_layers),
        .weights_ready(weights_ready), .abort(abort), .ub_rd_valid(ub_rd_valid),
        .wf_pop(wf_pop), .capture_col(capture_col), .ub_rd_ready(ub_rd_ready),
        .buf_sel(buf_sel), .refill_en(refill_en), .acc_clear(acc_clear),
        .acc_align_clear(acc_align_clear), .accum_en(accum_en), .mmu_valid(mmu_valid),
        .state(state), .cycle_cnt(cycle_cnt), .layer(layer), .busy(busy),
        .layer_complete(layer_complete), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Segment record: {state[3:0], length[7:0], layer[2:0], buf_sel}
    logic [15:0] exp_q[$];
    int          ww_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_seg(input int st, input int len, input int lay);
        logic [3:0] s4;
        logic [7:0] l8;
        logic [2:0] y3;
        s4 = 4'(st);
        l8 = 8'(len);
        y3 = 3'(lay);
        exp_q.push_back({s4, l8, y3, y3[0]});
    endfunction

    function automatic logic [N+9:0] exp_strobes(input logic [3:0] es, input int p, input int si,
                                                 input bit acc, input bit urv);
        logic [N-1:0] cc;
        cc = '0;
        if (es == 4'd1 && p >= 1 && p <= N) cc[p-1] = 1'b1;
        return {es == 4'd1, cc, es == 4'd3,
                (es == 4'd3 && p >= N && urv) || (es == 4'd4 && p < N),
                es == 4'd4 || es == 4'd5,
                es == 4'd1 && p == 0 && si == 0,
                es == 4'd2 && p == 0,
                acc, 1'b1, es == 4'd8, 1'b0};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    bit          mon_en = 0;
    bit          active = 0, acc_on = 0, done_exp = 0;
    int          pos = 0, seg_idx = 0;
    logic [LW-1:0] idle_layer = '0;
    logic        idle_buf = 1'b0;
    logic [15:0] cur;
    logic [3:0]  es;
    int          elen;
    logic [N+9:0] act_vec;

    always @(negedge clk) begin
        if (mon_en) begin
            act_vec = {wf_pop, capture_col, ub_rd_ready, mmu_valid, refill_en, acc_clear,
                       acc_align_clear, accum_en, busy, layer_complete, done};
            if (active && exp_q.size() > 0) begin
                cur  = exp_q[0];
                es   = cur[15:12];
                elen = int'(cur[11:4]);
                chk("state", 32'(state), 32'(es));
                chk("cycle_cnt", 32'(cycle_cnt), 32'(pos));
                chk("layer", 32'(layer), 32'(cur[3:1]));
                chk("buf_sel", 32'(buf_sel), 32'(cur[0]));
                chk("strobes", 32'(act_vec), 32'(exp_strobes(es, pos, seg_idx, acc_on, ub_rd_valid)));
            end else begin
                chk("idle_state", 32'(state), 32'd0);
                chk("idle_strobes", 32'(act_vec), 32'(done_exp));
                chk("idle_layer", 32'(layer), 32'(idle_layer));
                chk("idle_buf", 32'(buf_sel), 32'(idle_buf));
            end

            if (reset || (active && abort)) begin
                exp_q.delete();
                active = 0; pos = 0; acc_on = 0; done_exp = 0;
                idle_layer = '0; idle_buf = 1'b0;
            end else if (active && exp_q.size() > 0) begin
                if (es == 4'd3) acc_on = 1;
                pos++;
                done_exp = 0;
                if (pos == elen) begin
                    void'(exp_q.pop_front());
                    pos = 0;
                    seg_idx++;
                    if (exp_q.size() == 0) begin
                        active = 0; acc_on = 0; done_exp = 1;
                        idle_layer = cur[3:1]; idle_buf = cur[0];
                    end
                end
            end else begin
                done_exp = 0;
                if (start && !abort) begin
                    active = 1; pos = 0; seg_idx = 0; acc_on = 0;
                end
            end
        end
    end

    // ---------------- driver ----------------
    bit in_ww = 0;
    int ww_cnt = 0, cur_w = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (state == 4'd7) begin
            if (!in_ww) begin
                in_ww  = 1;
                ww_cnt = 0;
                cur_w  = (ww_q.size() > 0) ? ww_q.pop_front() : 0;
            end
            weights_ready = (ww_cnt >= cur_w);
            ww_cnt++;
        end else begin
            in_ww = 0;
            weights_ready = 1'($urandom_range(0, 1));
        end
        ub_rd_valid = 1'($urandom_range(0, 1));
    endtask

    task automatic run(input logic [LW-1:0] nl, input int hold, input int abort_at,
                       input int rst_at, input int w_fixed);
        int nlay, w;
        bit finished;
        nlay = (nl == 0) ? 1 : ((int'(nl) > MAXL) ? MAXL : int'(nl));
        push_seg(1, N + 1, 0);
        push_seg(2, ACT, 0);
        push_seg(3, N + 1, 0);
        push_seg(4, 2 * N + 3, 0);
        for (int i = 1; i < nlay; i++) begin
            w = (w_fixed >= 0) ? w_fixed : int'($urandom_range(0, 4));
            ww_q.push_back(w);
            push_seg(5, TC, i - 1);
            push_seg(6, 1, i - 1);
            push_seg(7, w + 1, i);
            push_seg(1, N + 1, i);
            push_seg(3, N + 1, i);
            push_seg(4, 2 * N + 3, i);
        end
        push_seg(8, DH + 1, nlay - 1);

        start = 1'b1; num_layers = nl; abort = 1'b0;
        finished = 0;
        for (int c = 1; c <= 600; c++) begin
            tick();
            if (c >= hold) start = 1'b0;
            num_layers = LW'($urandom_range(0, 7));
            abort = (c == abort_at);
            reset = (c == rst_at) || (c == rst_at + 1);
            if (abort || reset) ww_q.delete();
            if (c > 1 && !busy && !start && !abort && !reset) begin
                finished = 1;
                break;
            end
        end
        chk("run_timeout", 32'(finished), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; weights_ready = 1'b0;
        ub_rd_valid = 1'b0; num_layers = '0;
        tick();
        mon_en = 1;
        tick(); tick();
        reset = 1'b0;
        tick(); tick();

        run(3'd1, 1, -10, -10, 0);          // single layer, 26 busy cycles
        tick();
        run(3'd2, 1, -10, -10, 0);          // second layer skips LOAD_ACT
        run(3'd2, 1, -10, -10, 9);          // WAIT_WEIGHTS dwell of 10 cycles
        run(3'd1, 1, 14, -10, 0);           // abort on DRAIN cycle 3
        run(3'd1, 1, -10, -10, 0);
        run(3'd0, 1, -10, -10, 0);          // 0 clamps to 1 layer
        run(3'd7, 10, -10, -10, 1);         // clamps to 4 layers, start held
        start = 1'b1; abort = 1'b1;         // abort beats start in IDLE
        tick();
        start = 1'b0; abort = 1'b0;
        tick(); tick();
        run(3'd3, 1, -10, 20, 0);           // reset mid-run
        tick(); tick();

        for (int r = 0; r < 14; r++) begin
            int ab;
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 60)) : -10;
            run(LW'($urandom_range(0, 7)), int'($urandom_range(1, 4)), ab, -10, -1);
            if ($urandom_range(0, 1) == 1) tick();
        end

        tick(); tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
